// File: rtl/stream_sequencer.sv
// stream_sequencer
//   Programmable stimulus source. Up to DEPTH words are loaded while idle,
//   then played out on a valid/ready stream on `start`, with last-beat
//   marking, backpressure handling and a one-cycle completion pulse.
//
//   Optional feature macro: SEQ_LOOP_EN
//     defined   -> `loop` high at the last-beat transfer wraps back to entry 0
//     undefined -> `loop` is accepted but ignored
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   wr_en      : sequence memory write strobe (honoured only while idle)
//   wr_addr    : write address
//   wr_data    : write data
//   len        : number of entries to play, sampled with start (clamped to DEPTH)
//   start      : begin playback (level, idle only)
//   stop       : abort playback, no done
//   loop       : repeat the sequence (SEQ_LOOP_EN only)
//   dout_ready : consumer accepts the current beat
//   dout       : current stream word (registered)
//   dout_valid : dout is valid
//   dout_last  : current beat is entry len_q-1
//   busy       : registered copy of the PLAY state
//   done       : one-cycle pulse after the final beat of a non-looping playback
module stream_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic                       dout_ready,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic                       dout_last,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [LW-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0]         len_eff;
  logic [AW-1:0]         ptr_inc;
  logic [DATA_WIDTH-1:0] first_word;
  logic                  xfer;
  logic                  loop_go;

`ifdef SEQ_LOOP_EN
  assign loop_go = loop;
`else
  assign loop_go = 1'b0;
  logic unused_loop;
  assign unused_loop = loop;
`endif

  // Memory is intentionally not reset; it survives a reset for replay.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    len_eff = (len > DEPTH_L) ? DEPTH_L : len;
    ptr_inc = ptr_q + AW'(1);
    xfer    = valid_q && dout_ready;
    // A write to entry 0 in the start cycle must be seen by the first beat,
    // so bypass the array on that address.
    first_word = (wr_en && wr_addr == '0) ? wr_data : mem[0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && len != '0) begin
          state_d = PLAY;
          len_d   = len_eff;
          ptr_d   = '0;
          dout_d  = first_word;
          valid_d = 1'b1;
          last_d  = (len_eff == LW'(1));
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (xfer) begin
          if (last_q) begin
            if (loop_go) begin
              ptr_d  = '0;
              dout_d = mem[0];
              last_d = (len_q == LW'(1));
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            ptr_d  = ptr_inc;
            dout_d = mem[ptr_inc];
            last_d = ({1'b0, ptr_inc} == len_q - LW'(1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stream_sequencer.sv
module tb_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  len;
  logic        start;
  logic        stop;
  logic        loop;
  logic        dout_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [16];
  int basic [9] = '{2, 2, 6, 0, 14, 12, 0, 1, 2};

  stream_sequencer #(.DATA_WIDTH(32), .DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len        (len),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] val);
    wr_en   = 1'b1;
    wr_addr = addr[3:0];
    wr_data = val;
    step();
    wr_en   = 1'b0;
    model[addr] = val;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; len = 0;
    start = 0; stop = 0; loop = 0; dout_ready = 0;
    step(); step();
    checks++;
    if ({dout, dout_valid, dout_last, busy, done} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got dout=%0h v=%b l=%b busy=%b done=%b exp all 0",
               dout, dout_valid, dout_last, busy, done);
    end
    #3 reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 9; i++) load(i, basic[i]);
    len = 9; dout_ready = 1; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dout !== 32'(basic[i]) || dout_valid !== 1'b1 || dout_last !== (i == 8) || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_beat%0d got dout=%0h v=%b l=%b busy=%b exp dout=%0h v=1 l=%b busy=1",
                 i, dout, dout_valid, dout_last, busy, basic[i], (i == 8));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got done=%b v=%b busy=%b exp done=1 v=0 busy=0", done, dout_valid, busy);
    end
  endtask

  // Called in the done cycle left by test_basic.
  task automatic test_back_to_back();
    len = 2; start = 1;
    step();
    start = 0;
    checks++;
    if (dout !== 32'd2 || dout_valid !== 1'b1 || dout_last !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got dout=%0h v=%b l=%b done=%b exp dout=2 v=1 l=0 done=0",
               dout, dout_valid, dout_last, done);
    end
    step();
    checks++;
    if (dout !== 32'd2 || dout_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got dout=%0h l=%b exp dout=2 l=1", dout, dout_last);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got %b exp 1", done);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic r [5]        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] e [5] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd6};
    len = 3; dout_ready = 1; start = 1;
    step();
    start = 0;
    for (int c = 0; c < 5; c++) begin
      dout_ready = r[c];
      checks++;
      if (dout !== e[c] || dout_valid !== 1'b1 || dout_last !== (c == 4)) begin
        failures++;
        $display("FAIL bp_cycle%0d got dout=%0h v=%b l=%b exp dout=%0h v=1 l=%b",
                 c, dout, dout_valid, dout_last, e[c], (c == 4));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done got done=%b v=%b exp done=1 v=0", done, dout_valid);
    end
    dout_ready = 1;
    step();
  endtask

  task automatic test_len_zero();
    len = 0; start = 1;
    step();
    start = 0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dout_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL len0_cycle%0d got v=%b done=%b busy=%b exp 0 0 0", c, dout_valid, done, busy);
      end
      step();
    end
  endtask

  task automatic test_len_clamp();
    int beats = 0;
    int cyc = 0;
    for (int i = 0; i < 16; i++) load(i, 32'(i * 3 + 1));
    len = 20; dout_ready = 1; start = 1;
    step();
    start = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (dout_valid === 1'b1) begin
        if (beats < 16) begin
          checks++;
          if (dout !== model[beats] || dout_last !== (beats == 15)) begin
            failures++;
            $display("FAIL clamp_beat%0d got dout=%0h l=%b exp dout=%0h l=%b",
                     beats, dout, dout_last, model[beats], (beats == 15));
          end
        end
        beats++;
      end
      step();
      cyc++;
    end
    checks++;
    if (cyc >= 40) begin
      failures++;
      $display("FAIL clamp_timeout got no done within 40 cycles exp done");
    end
    checks++;
    if (beats != 16) begin
      failures++;
      $display("FAIL clamp_count got %0d beats exp 16", beats);
    end
    step();
  endtask

  task automatic test_write_during_play();
    len = 2; start = 1;
    step();
    start = 0;
    wr_en = 1; wr_addr = 0; wr_data = 32'd5;
    step();
    wr_en = 0;
    step();
    step();
    len = 1; start = 1;
    step();
    start = 0;
    checks++;
    if (dout !== model[0] || dout_valid !== 1'b1 || dout_last !== 1'b1) begin
      failures++;
      $display("FAIL wr_in_play got dout=%0h v=%b l=%b exp dout=%0h v=1 l=1",
               dout, dout_valid, dout_last, model[0]);
    end
    step();
    step();
    wr_en = 1; wr_addr = 0; wr_data = 32'h77; start = 1; len = 1;
    step();
    wr_en = 0; start = 0;
    model[0] = 32'h77;
    checks++;
    if (dout !== 32'h77 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_with_start got dout=%0h v=%b exp dout=77 v=1", dout, dout_valid);
    end
    step();
    step();
  endtask

  task automatic test_stop();
    int xfers = 0;
    logic seen_done = 1'b0;
    len = 6; dout_ready = 1; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout !== model[i] || dout_valid !== 1'b1) begin
        failures++;
        $display("FAIL stop_beat%0d got dout=%0h v=%b exp dout=%0h v=1", i, dout, dout_valid, model[i]);
      end
      if (dout_valid === 1'b1 && dout_ready === 1'b1) xfers++;
      if (i == 2) stop = 1;
      step();
    end
    stop = 0;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle got v=%b busy=%b exp 0 0", dout_valid, busy);
    end
    for (int c = 0; c < 5; c++) begin
      if (done === 1'b1) seen_done = 1'b1;
      if (dout_valid === 1'b1) xfers++;
      step();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_done got done asserted exp never");
    end
    checks++;
    if (xfers != 3) begin
      failures++;
      $display("FAIL stop_xfers got %0d exp 3", xfers);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    len = 9; dout_ready = 1; start = 1;
    step();
    start = 0;
    step(); step(); step();
    checks++;
    if (dout !== model[3] || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_beat4 got dout=%0h v=%b exp dout=%0h v=1", dout, dout_valid, model[3]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, dout_last, busy, done} !== 36'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got dout=%0h v=%b l=%b busy=%b done=%b exp all 0",
               dout, dout_valid, dout_last, busy, done);
    end
    #1 reset = 1'b0;
    step();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout !== model[i] || dout_valid !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_replay%0d got dout=%0h v=%b exp dout=%0h v=1", i, dout, dout_valid, model[i]);
      end
      step();
    end
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc >= 20) begin
      failures++;
      $display("FAIL rstmid_done got no done within 20 cycles exp done");
    end
    step();
  endtask

  task automatic test_loop();
    for (int i = 0; i < 4; i++) load(i, 32'(i));
    len = 4; loop = 1; dout_ready = 1; start = 1;
    step();
    start = 0;
`ifdef SEQ_LOOP_EN
    for (int c = 0; c < 8; c++) begin
      if (c == 5) loop = 0;
      checks++;
      if (dout !== 32'(c % 4) || dout_valid !== 1'b1 || dout_last !== (c % 4 == 3) || done !== 1'b0) begin
        failures++;
        $display("FAIL loop_cycle%0d got dout=%0h v=%b l=%b done=%b exp dout=%0h v=1 l=%b done=0",
                 c, dout, dout_valid, dout_last, done, c % 4, (c % 4 == 3));
      end
      step();
    end
`else
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dout !== 32'(c) || dout_valid !== 1'b1 || dout_last !== (c == 3)) begin
        failures++;
        $display("FAIL noloop_cycle%0d got dout=%0h v=%b l=%b exp dout=%0h v=1 l=%b",
                 c, dout, dout_valid, dout_last, c, (c == 3));
      end
      step();
    end
`endif
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL loop_end got done=%b v=%b exp done=1 v=0", done, dout_valid);
    end
    loop = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_len_zero();
    test_len_clamp();
    test_write_during_play();
    test_stop();
    test_reset_mid();
    test_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_sequencer.md
# stream_sequencer

Programmable stimulus source that plays a stored sequence of data words onto a valid/ready stream, one word per accepted beat. It is the producing end of the `din` stream consumed by the running-statistics trackers (such as the second-largest tracker). Hardware supplies the sequence instead of a bench. Software or a bench loads up to `DEPTH` words, then issues `start`; the block streams them with last-beat marking, honours backpressure, and reports completion.

## Interface
- `DATA_WIDTH`, 32: width of each stored and streamed word.
- `DEPTH`, 16: number of sequence entries; must be a power of two, minimum 2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `wr_en` input 1: write strobe for sequence memory.
- `wr_addr` input $clog2(DEPTH): write address.
- `wr_data` input DATA_WIDTH: write data.
- `len` input $clog2(DEPTH)+1: number of entries to play; sampled with `start`.
- `start` input 1: begin playback. Level-sampled; acts only in IDLE.
- `stop` input 1: abort playback.
- `loop` input 1: repeat the sequence; only functional with `SEQ_LOOP_EN`.
- `dout_ready` input 1: consumer accepts the current beat.
- `dout` output DATA_WIDTH: current stream word, registered.
- `dout_valid` output 1: `dout` is valid.
- `dout_last` output 1: the current beat is entry `len_q-1`.
- `busy` output 1: high while the state is PLAY.
- `done` output 1: one-cycle pulse after the final beat of a non-looping playback.

## Operation
- **States:** IDLE and PLAY.
- **Reset:** `reset` high asynchronously forces the state to IDLE, the pointer to 0, and `len_q` to 0. It drives `dout`, `dout_valid`, `dout_last`, `busy`, and `done` to 0. Memory contents are not reset.
- **Memory writes:**
  - `wr_en` in IDLE writes `mem[wr_addr] <= wr_data`.
  - `wr_en` in PLAY is ignored.
  - If `wr_en` and `start` occur in the same cycle, the write completes first. Entry 0 is read after the write.
- **IDLE:**
  - `start` with `len == 0`: ignored; the block stays in IDLE.
  - `start` with `len > DEPTH`: `len_q` is clamped to `DEPTH`.
  - Otherwise: `len_q <= len`, pointer `<= 0`, and the block moves to PLAY.
- **PLAY, beat presentation:**
  - `dout = mem[ptr]` and `dout_valid = 1`.
  - `dout_last = (ptr == len_q-1)`.
- **PLAY, handshake:**
  - A beat transfers when `dout_valid && dout_ready`.
  - On transfer of a non-last beat, the pointer increments and the next word appears on the following cycle. There are no bubbles.
- **PLAY, backpressure:** while `dout_ready` is low, `dout`, `dout_valid`, and `dout_last` hold stable.
- **Last beat, non-loop:** on transfer of the last beat, the block returns to IDLE. `dout_valid` and `dout_last` go to 0 and `done` pulses for 1 cycle.
- **`stop` in PLAY:**
  - The block goes to IDLE on the next edge and `dout_valid` drops.
  - `done` is not asserted.
  - If `dout_ready` is high in the same cycle, that beat counts as transferred.
  - `stop` takes priority over loop wrap and over last-beat completion; `done` is suppressed.
  - `stop` in IDLE has no effect.
- **`start` in PLAY:** ignored. Changes to `len` in PLAY are ignored because `len_q` is held.
- **Reset mid-playback:** the block returns to IDLE immediately and no `done` is produced. Memory is retained, so a later `start` replays it.

## Timing
- `start` sampled at edge N puts the first beat (`mem[0]`) on `dout` with `dout_valid` = 1 after edge N.
- With `dout_ready` held at 1, a playback of length L occupies exactly L consecutive valid cycles.
- `done` goes high in the cycle after the last transfer and coincides with `dout_valid` = 0.
- `busy` equals the PLAY state and is registered.
- A new `start` is accepted in the same cycle that `done` is high, giving back-to-back playback with a single-cycle gap.
- A write to `mem[k]` at edge M is visible to a playback started at edge M or later.

## Configuration
- `SEQ_LOOP_EN` defined:
  - When the last beat transfers with `loop` = 1, the pointer wraps to 0 and PLAY continues with no gap cycle. `done` is not pulsed.
  - `dout_last` still marks each pass.
  - Deasserting `loop` before a last-beat transfer ends playback normally, with `done`.
- `SEQ_LOOP_EN` undefined:
  - The `loop` port exists but is ignored.
  - Every playback ends after `len_q` beats with `done`.

## Test plan
- **Basic playback:** load 2,2,6,0,E,C,0,1,2 at addresses 0–8, set `len` = 9, hold `dout_ready` = 1, pulse `start`. Expect 9 consecutive beats in that order, `dout_last` only on the 9th (value 2), `done` on the next cycle, and `busy` low afterwards.
- **Backpressure:** same load with `len` = 3, drive `dout_ready` = 1,0,0,1,1. Expect `dout` to hold 2 through the stalled cycles, transfers of 2,2,6, and `done` after the third transfer.
- **Boundaries:**
  - `start` with `len` = 0: no `dout_valid` and no `done`.
  - `len` = 20 with `DEPTH` = 16: exactly 16 beats.
  - `wr_en` to address 0 with value 5 during PLAY: the replayed entry 0 is unchanged.
- **Stop:** play `len` = 6 and assert `stop` on the 3rd beat with `dout_ready` = 1. Expect 3 beats transferred, `dout_valid` = 0 on the next cycle, and `done` never asserted.
- **Reset mid-operation:** pulse `reset` high between edges during beat 4. Expect all outputs 0 immediately. A following `start` replays from entry 0 with the original data.
- **Loop (with `SEQ_LOOP_EN`):** load 0,1,2,3 with `len` = 4 and `loop` = 1. Expect 0,1,2,3,0,1,… with no gap. Drop `loop` during the second pass; playback ends after that pass's 3 with `done`.
